// File: rtl/mm_row_scheduler_if.sv
// Bus bundle between the row scheduler and its environment:
// controller start/done, dot-product unit, A/B row memories and C writer.
interface mm_row_scheduler_if #(
    parameter int LOG_BATCH_SIZE      = 3,
    parameter int OUTPUT_FEATURES     = 8,
    parameter int LOG_OUTPUT_FEATURES = 3,
    parameter int OUTPUT_WIDTH        = 16
);
    logic                                    start;
    logic                                    busy;
    logic                                    done;
    logic [LOG_BATCH_SIZE-1:0]               inputAddr;
    logic [LOG_OUTPUT_FEATURES-1:0]          weightAddr;
    logic                                    dpStart;
    logic                                    dpDone;
    logic [OUTPUT_WIDTH-1:0]                 dpResult;
    logic [OUTPUT_FEATURES*OUTPUT_WIDTH-1:0] outputData;
    logic [LOG_BATCH_SIZE-1:0]               outputAddr;
    logic                                    outputWrEn;
    logic                                    outputReady;

    modport master (
        input  start,
        output busy,
        output done,
        output inputAddr,
        output weightAddr,
        output dpStart,
        input  dpDone,
        input  dpResult,
        output outputData,
        output outputAddr,
        output outputWrEn,
        input  outputReady
    );

    modport slave (
        output start,
        input  busy,
        input  done,
        input  inputAddr,
        input  weightAddr,
        input  dpStart,
        output dpDone,
        output dpResult,
        input  outputData,
        input  outputAddr,
        input  outputWrEn,
        output outputReady
    );
endinterface

// File: rtl/mm_row_scheduler.sv
// Row sequencer for C = A * B^T using one shared dot-product unit.
// Collects one row of C in a buffer, then hands it to the writer.
module mm_row_scheduler #(
    parameter int BATCH_SIZE          = 8,
    parameter int LOG_BATCH_SIZE      = 3,
    parameter int OUTPUT_FEATURES     = 8,
    parameter int LOG_OUTPUT_FEATURES = 3,
    parameter int OUTPUT_WIDTH        = 16
) (
    input  logic               clk,
    input  logic               rst,
    mm_row_scheduler_if.master bus
);
    localparam logic [LOG_BATCH_SIZE-1:0] ROW_LAST =
        LOG_BATCH_SIZE'(BATCH_SIZE - 1);
    localparam logic [LOG_OUTPUT_FEATURES-1:0] COL_LAST =
        LOG_OUTPUT_FEATURES'(OUTPUT_FEATURES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        WRITE,
        FINISH
    } state_t;

    state_t                         state_q, state_d;
    logic [LOG_BATCH_SIZE-1:0]      row_q, row_d;
    logic [LOG_OUTPUT_FEATURES-1:0] col_q, col_d;
    logic                           buf_we;
    logic [OUTPUT_WIDTH-1:0]        buf_q [OUTPUT_FEATURES];
    logic [OUTPUT_FEATURES*OUTPUT_WIDTH-1:0] data_c;

    // State and row/column counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    // Next state, counter updates and handshake outputs
    always_comb begin
        state_d        = state_q;
        row_d          = row_q;
        col_d          = col_q;
        buf_we         = 1'b0;
        bus.busy       = 1'b1;
        bus.done       = 1'b0;
        bus.dpStart    = 1'b0;
        bus.outputWrEn = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) begin
                    row_d   = '0;
                    col_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                bus.dpStart = 1'b1;
                state_d     = WAIT;
            end
            WAIT: begin
                if (bus.dpDone) begin
                    buf_we = 1'b1;
                    if (col_q == COL_LAST) begin
                        state_d = WRITE;
                    end else begin
                        col_d   = col_q + LOG_OUTPUT_FEATURES'(1);
                        state_d = ISSUE;
                    end
                end
            end
            WRITE: begin
                bus.outputWrEn = 1'b1;
                if (bus.outputReady) begin
                    if (row_q == ROW_LAST) begin
                        state_d = FINISH;
                    end else begin
                        row_d   = row_q + LOG_BATCH_SIZE'(1);
                        col_d   = '0;
                        state_d = ISSUE;
                    end
                end
            end
            FINISH: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Row buffer: one slot per column, written on accepted results only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < OUTPUT_FEATURES; i++) begin
                buf_q[i] <= '0;
            end
        end else if (buf_we) begin
            buf_q[col_q] <= bus.dpResult;
        end
    end

    // Flatten the buffer onto the writer data bus
    always_comb begin
        data_c = '0;
        for (int i = 0; i < OUTPUT_FEATURES; i++) begin
            data_c[i*OUTPUT_WIDTH +: OUTPUT_WIDTH] = buf_q[i];
        end
    end

    assign bus.outputData = data_c;
    assign bus.inputAddr  = row_q;
    assign bus.weightAddr = col_q;
    assign bus.outputAddr = row_q;
endmodule

// File: tb/tb_mm_row_scheduler.sv
// Bench for mm_row_scheduler: 8x8 build plus a 3x5 build,
// dot-product latency model and row scoreboard.
module tb_mm_row_scheduler;
    logic clk;
    logic rst;

    int vectors;
    int miscompares;

    typedef struct {
        logic [2:0]   addr;
        logic [127:0] data;
    } exp8_t;

    typedef struct {
        logic [1:0]  addr;
        logic [79:0] data;
    } exp35_t;

    exp8_t  q8[$];
    exp35_t q35[$];

    logic        start8, inj8, rdy8, mdl_done8;
    logic [15:0] mdl_res8;
    logic        start35, rdy35, mdl_done35;
    logic [15:0] mdl_res35;
    int          lat8, lat35;
    int          cyc8, cyc35, due8, due35;
    int          wr8, wr35;

    mm_row_scheduler_if #(
        .LOG_BATCH_SIZE(3), .OUTPUT_FEATURES(8),
        .LOG_OUTPUT_FEATURES(3), .OUTPUT_WIDTH(16)
    ) if8 ();

    mm_row_scheduler_if #(
        .LOG_BATCH_SIZE(2), .OUTPUT_FEATURES(5),
        .LOG_OUTPUT_FEATURES(3), .OUTPUT_WIDTH(16)
    ) if35 ();

    mm_row_scheduler #(
        .BATCH_SIZE(8), .LOG_BATCH_SIZE(3), .OUTPUT_FEATURES(8),
        .LOG_OUTPUT_FEATURES(3), .OUTPUT_WIDTH(16)
    ) u8 (
        .clk(clk),
        .rst(rst),
        .bus(if8)
    );

    mm_row_scheduler #(
        .BATCH_SIZE(3), .LOG_BATCH_SIZE(2), .OUTPUT_FEATURES(5),
        .LOG_OUTPUT_FEATURES(3), .OUTPUT_WIDTH(16)
    ) u35 (
        .clk(clk),
        .rst(rst),
        .bus(if35)
    );

    assign if8.start       = start8;
    assign if8.dpDone      = mdl_done8 | inj8;
    assign if8.dpResult    = inj8 ? 16'hDEAD : mdl_res8;
    assign if8.outputReady = rdy8;

    assign if35.start       = start35;
    assign if35.dpDone      = mdl_done35;
    assign if35.dpResult    = mdl_res35;
    assign if35.outputReady = rdy35;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Dot-product unit model, 8x8 build: result r*16+c, L cycles after dpStart
    always @(posedge clk) begin
        #1;
        cyc8++;
        mdl_done8 = 1'b0;
        if (rst) begin
            due8 = -1;
        end else begin
            if (due8 == cyc8) begin
                mdl_done8 = 1'b1;
                mdl_res8  = 16'(int'(if8.inputAddr) * 16 + int'(if8.weightAddr));
                due8      = -1;
            end
            if (if8.dpStart) due8 = cyc8 + lat8;
        end
    end

    // Dot-product unit model, 3x5 build
    always @(posedge clk) begin
        #1;
        cyc35++;
        mdl_done35 = 1'b0;
        if (rst) begin
            due35 = -1;
        end else begin
            if (due35 == cyc35) begin
                mdl_done35 = 1'b1;
                mdl_res35  = 16'(int'(if35.inputAddr) * 16 + int'(if35.weightAddr));
                due35      = -1;
            end
            if (if35.dpStart) due35 = cyc35 + lat35;
        end
    end

    // Scoreboard, 8x8 build: compare every accepted row
    always @(negedge clk) begin
        if (!rst && if8.outputWrEn && if8.outputReady) begin
            exp8_t e;
            wr8++;
            vectors++;
            if (q8.size() == 0) begin
                miscompares++;
                $display("FAIL row8_unexpected addr got %0d want none", if8.outputAddr);
            end else begin
                e = q8.pop_front();
                if (if8.outputAddr !== e.addr || if8.outputData !== e.data) begin
                    miscompares++;
                    $display("FAIL row8 addr got %0d want %0d data got %h want %h",
                             if8.outputAddr, e.addr, if8.outputData, e.data);
                end
            end
        end
    end

    // Scoreboard, 3x5 build
    always @(negedge clk) begin
        if (!rst && if35.outputWrEn && if35.outputReady) begin
            exp35_t e;
            wr35++;
            vectors++;
            if (q35.size() == 0) begin
                miscompares++;
                $display("FAIL row35_unexpected addr got %0d want none", if35.outputAddr);
            end else begin
                e = q35.pop_front();
                if (if35.outputAddr !== e.addr || if35.outputData !== e.data) begin
                    miscompares++;
                    $display("FAIL row35 addr got %0d want %0d data got %h want %h",
                             if35.outputAddr, e.addr, if35.outputData, e.data);
                end
            end
        end
    end

    task automatic push_rows8();
        exp8_t e;
        for (int r = 0; r < 8; r++) begin
            e.addr = 3'(r);
            e.data = '0;
            for (int c = 0; c < 8; c++) e.data[c*16 +: 16] = 16'(r * 16 + c);
            q8.push_back(e);
        end
    endtask

    // Runs one 8x8 job; optional writer stall on one row and noise
    task automatic run_job8(input int L, input int stall_row, input int stall_len,
                            input bit noise, output int done_at, output int dwidth,
                            output int ds, output int gap2, output int stall_cyc,
                            output int stall_bad);
        int n, last_ds, stall_left;
        bit have_snap;
        logic [127:0] snap_d;
        logic [2:0] snap_a;
        lat8 = L;
        push_rows8();
        done_at = -1; dwidth = 0; ds = 0; gap2 = 0;
        stall_cyc = 0; stall_bad = 0; stall_left = stall_len;
        last_ds = -100; have_snap = 0; snap_d = '0; snap_a = '0;
        @(negedge clk);
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        n = 0;
        while (n < 3000) begin
            n++;
            if (stall_left > 0 && if8.outputWrEn && int'(if8.outputAddr) == stall_row) begin
                rdy8 = 1'b0;
                stall_left--;
            end else begin
                rdy8 = 1'b1;
            end
            if (noise) begin
                inj8   = if8.dpStart;
                start8 = (n % 37 == 5);
            end
            @(negedge clk);
            if (if8.dpStart) begin
                ds++;
                if (n - last_ds == 2) gap2++;
                last_ds = n;
            end
            if (if8.outputWrEn) begin
                if (have_snap && (if8.outputData != snap_d || if8.outputAddr != snap_a))
                    stall_bad++;
                if (if8.dpStart) stall_bad++;
                if (!rdy8) begin
                    stall_cyc++;
                    snap_d = if8.outputData;
                    snap_a = if8.outputAddr;
                    have_snap = 1;
                end else begin
                    have_snap = 0;
                end
            end
            if (if8.done) begin
                if (done_at < 0) done_at = n;
                dwidth++;
            end else if (done_at >= 0) begin
                break;
            end
            @(posedge clk);
            #1;
        end
        start8 = 1'b0;
        inj8   = 1'b0;
        rdy8   = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if (if8.busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", if8.busy); end
        vectors++; if (if8.done !== 1'b0) begin miscompares++; $display("FAIL rst_done got %b want 0", if8.done); end
        vectors++; if (if8.dpStart !== 1'b0) begin miscompares++; $display("FAIL rst_dpStart got %b want 0", if8.dpStart); end
        vectors++; if (if8.outputWrEn !== 1'b0) begin miscompares++; $display("FAIL rst_wren got %b want 0", if8.outputWrEn); end
        vectors++; if (if8.inputAddr !== 3'd0) begin miscompares++; $display("FAIL rst_inaddr got %0d want 0", if8.inputAddr); end
        vectors++; if (if8.weightAddr !== 3'd0) begin miscompares++; $display("FAIL rst_waddr got %0d want 0", if8.weightAddr); end
        vectors++; if (if8.outputAddr !== 3'd0) begin miscompares++; $display("FAIL rst_oaddr got %0d want 0", if8.outputAddr); end
        vectors++; if (if8.outputData !== 128'd0) begin miscompares++; $display("FAIL rst_data got %h want 0", if8.outputData); end
        vectors++; if (if35.busy !== 1'b0) begin miscompares++; $display("FAIL rst35_busy got %b want 0", if35.busy); end
        vectors++; if (if35.outputData !== 80'd0) begin miscompares++; $display("FAIL rst35_data got %h want 0", if35.outputData); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int d, w, ds, g, sc, sb, wr0;
        wr0 = wr8;
        run_job8(4, -1, 0, 0, d, w, ds, g, sc, sb);
        vectors++; if (d !== 329) begin miscompares++; $display("FAIL basic_done_at got %0d want 329", d); end
        vectors++; if (w !== 1) begin miscompares++; $display("FAIL basic_done_width got %0d want 1", w); end
        vectors++; if (ds !== 64) begin miscompares++; $display("FAIL basic_dpstarts got %0d want 64", ds); end
        vectors++; if (wr8 - wr0 !== 8) begin miscompares++; $display("FAIL basic_writes got %0d want 8", wr8 - wr0); end
        vectors++; if (q8.size() !== 0) begin miscompares++; $display("FAIL basic_pending got %0d want 0", q8.size()); end
    endtask

    task automatic test_latency1();
        int d, w, ds, g, sc, sb;
        run_job8(1, -1, 0, 0, d, w, ds, g, sc, sb);
        vectors++; if (d !== 137) begin miscompares++; $display("FAIL l1_done_at got %0d want 137", d); end
        vectors++; if (g !== 56) begin miscompares++; $display("FAIL l1_gap2 got %0d want 56", g); end
        vectors++; if (ds !== 64) begin miscompares++; $display("FAIL l1_dpstarts got %0d want 64", ds); end
        vectors++; if (q8.size() !== 0) begin miscompares++; $display("FAIL l1_pending got %0d want 0", q8.size()); end
    endtask

    task automatic test_stall();
        int d, w, ds, g, sc, sb, wr0;
        wr0 = wr8;
        run_job8(4, 2, 5, 0, d, w, ds, g, sc, sb);
        vectors++; if (d !== 334) begin miscompares++; $display("FAIL stall_done_at got %0d want 334", d); end
        vectors++; if (sc !== 5) begin miscompares++; $display("FAIL stall_cycles got %0d want 5", sc); end
        vectors++; if (sb !== 0) begin miscompares++; $display("FAIL stall_unstable got %0d want 0", sb); end
        vectors++; if (wr8 - wr0 !== 8) begin miscompares++; $display("FAIL stall_writes got %0d want 8", wr8 - wr0); end
    endtask

    task automatic test_ignored();
        int d, w, ds, g, sc, sb, wr0;
        logic [127:0] row7;
        for (int c = 0; c < 8; c++) row7[c*16 +: 16] = 16'(7 * 16 + c);
        @(posedge clk);
        #1 inj8 = 1'b1;
        @(posedge clk);
        #1 inj8 = 1'b0;
        @(negedge clk);
        vectors++; if (if8.busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy got %b want 0", if8.busy); end
        vectors++; if (if8.weightAddr !== 3'd7) begin miscompares++; $display("FAIL idle_col got %0d want 7", if8.weightAddr); end
        vectors++; if (if8.inputAddr !== 3'd7) begin miscompares++; $display("FAIL idle_row got %0d want 7", if8.inputAddr); end
        vectors++; if (if8.outputData !== row7) begin miscompares++; $display("FAIL idle_buf got %h want %h", if8.outputData, row7); end
        wr0 = wr8;
        run_job8(4, -1, 0, 1, d, w, ds, g, sc, sb);
        vectors++; if (d !== 329) begin miscompares++; $display("FAIL noise_done_at got %0d want 329", d); end
        vectors++; if (wr8 - wr0 !== 8) begin miscompares++; $display("FAIL noise_writes got %0d want 8", wr8 - wr0); end
        vectors++; if (ds !== 64) begin miscompares++; $display("FAIL noise_dpstarts got %0d want 64", ds); end
    endtask

    task automatic test_reset_mid();
        int k, wr0;
        lat8 = 4;
        push_rows8();
        @(negedge clk);
        start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        k = 0;
        while (!(if8.inputAddr == 3'd3 && if8.weightAddr == 3'd5) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        vectors++; if (k >= 2000) begin miscompares++; $display("FAIL mid_reach got timeout want row3 col5"); end
        #2 rst = 1'b1;
        #1;
        wr0 = wr8;
        vectors++; if (if8.busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy got %b want 0", if8.busy); end
        vectors++; if (if8.inputAddr !== 3'd0) begin miscompares++; $display("FAIL mid_inaddr got %0d want 0", if8.inputAddr); end
        vectors++; if (if8.weightAddr !== 3'd0) begin miscompares++; $display("FAIL mid_waddr got %0d want 0", if8.weightAddr); end
        vectors++; if (if8.dpStart !== 1'b0 || if8.outputWrEn !== 1'b0 || if8.done !== 1'b0) begin
            miscompares++; $display("FAIL mid_ctrl got %b%b%b want 000", if8.dpStart, if8.outputWrEn, if8.done); end
        vectors++; if (if8.outputData !== 128'd0) begin miscompares++; $display("FAIL mid_data got %h want 0", if8.outputData); end
        q8.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++; if (if8.busy !== 1'b0) begin miscompares++; $display("FAIL mid_post_busy got %b want 0", if8.busy); end
        vectors++; if (wr8 !== wr0) begin miscompares++; $display("FAIL mid_writes got %0d want %0d", wr8, wr0); end
        start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        @(negedge clk);
        vectors++; if (if8.inputAddr !== 3'd0 || if8.weightAddr !== 3'd0 || if8.dpStart !== 1'b1) begin
            miscompares++; $display("FAIL mid_restart got r%0d c%0d s%b want r0 c0 s1",
                                    if8.inputAddr, if8.weightAddr, if8.dpStart); end
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_small();
        int n, done_at, wr0;
        exp35_t e;
        lat35 = 2;
        for (int r = 0; r < 3; r++) begin
            e.addr = 2'(r);
            e.data = '0;
            for (int c = 0; c < 5; c++) e.data[c*16 +: 16] = 16'(r * 16 + c);
            q35.push_back(e);
        end
        wr0 = wr35;
        done_at = -1;
        @(negedge clk);
        start35 = 1'b1;
        @(posedge clk);
        #1 start35 = 1'b0;
        n = 0;
        while (n < 1000 && done_at < 0) begin
            n++;
            @(negedge clk);
            if (if35.done) done_at = n;
        end
        @(negedge clk);
        vectors++; if (done_at !== 49) begin miscompares++; $display("FAIL small_done_at got %0d want 49", done_at); end
        vectors++; if (wr35 - wr0 !== 3) begin miscompares++; $display("FAIL small_writes got %0d want 3", wr35 - wr0); end
        vectors++; if (if35.done !== 1'b0) begin miscompares++; $display("FAIL small_done_width got %b want 0", if35.done); end
        vectors++; if (q35.size() !== 0) begin miscompares++; $display("FAIL small_pending got %0d want 0", q35.size()); end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        start8 = 1'b0; inj8 = 1'b0; rdy8 = 1'b1;
        start35 = 1'b0; rdy35 = 1'b1;
        lat8 = 4; lat35 = 2;
        cyc8 = 0; cyc35 = 0; due8 = -1; due35 = -1;
        mdl_done8 = 1'b0; mdl_done35 = 1'b0;
        mdl_res8 = '0; mdl_res35 = '0;
        wr8 = 0; wr35 = 0;
        test_reset();
        test_basic();
        test_latency1();
        test_stall();
        test_ignored();
        test_reset_mid();
        test_small();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
